mem_port_arbiter: RTL and testbench

Shares the single unified memory port between the instruction-fetch stage and the load/store (MEM) stage of the RISC-V core. It sits between the pipeline and the memory model/bus. It accepts one request from each side, grants the port with fixed data-side priority and drives a registered request to memory. It returns read data with a one-cycle valid pulse, aborts transfers that exceed a wait-state limit, and generates stall signals for the pipeline.

---
 rtl/mem_port_arbiter.sv | 140 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and the load/store stage.
// Data side wins simultaneous requests; a busy transfer aborts after MAX_WAIT stalled cycles.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WAIT   = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    if_req,
  input  logic [ADDR_WIDTH-1:0]   if_addr,
  output logic [DATA_WIDTH-1:0]   if_rdata,
  output logic                    if_valid,
  output logic                    if_err,
  input  logic                    dm_req,
  input  logic                    dm_we,
  input  logic [ADDR_WIDTH-1:0]   dm_addr,
  input  logic [DATA_WIDTH-1:0]   dm_wdata,
  input  logic [DATA_WIDTH/8-1:0] dm_wstrb,
  output logic [DATA_WIDTH-1:0]   dm_rdata,
  output logic                    dm_valid,
  output logic                    dm_err,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  input  logic                    mem_ready,
  output logic                    stall_if,
  output logic                    stall_mem
);

  // state   | meaning
  // IDLE    | no transfer outstanding, arbitrate this cycle
  // IF_BUSY | fetch owns the port, waiting for mem_ready
  // DM_BUSY | load/store owns the port, waiting for mem_ready
  typedef enum logic [1:0] {IDLE = 2'd0, IF_BUSY = 2'd1, DM_BUSY = 2'd2} state_t;

  localparam int SW = DATA_WIDTH / 8;
  // A zero-width counter is illegal, so MAX_WAIT = 0 keeps one unused bit.
  localparam int CW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [CW-1:0] CNT_LIMIT = CW'(MAX_WAIT);

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [SW-1:0]         mem_wstrb_q, mem_wstrb_d;
  logic                  busy, timeout, done;

  always_comb begin
    busy    = (state_q == IF_BUSY) || (state_q == DM_BUSY);
    timeout = busy && (MAX_WAIT != 0) && (cnt_q == CNT_LIMIT) && !mem_ready;
    done    = busy && (mem_ready || timeout);
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    case (state_q)
      IDLE: begin
        if (dm_req) begin
          state_d     = DM_BUSY;
          cnt_d       = '0;
          mem_req_d   = 1'b1;
          mem_we_d    = dm_we;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          mem_wstrb_d = dm_wstrb;
        end else if (if_req) begin
          state_d     = IF_BUSY;
          cnt_d       = '0;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wstrb_d = '0;
        end
      end
      IF_BUSY, DM_BUSY: begin
        if (done) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
    end
  end

  // Completion is combinational so the pipeline can advance in the ready cycle.
  always_comb begin
    if_valid = (state_q == IF_BUSY) && done;
    if_err   = (state_q == IF_BUSY) && timeout;
    if_rdata = ((state_q == IF_BUSY) && mem_ready) ? mem_rdata : '0;
    dm_valid = (state_q == DM_BUSY) && done;
    dm_err   = (state_q == DM_BUSY) && timeout;
    dm_rdata = ((state_q == DM_BUSY) && mem_ready) ? mem_rdata : '0;
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;
  assign stall_if  = if_req & ~if_valid;
  assign stall_mem = dm_req & ~dm_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, hand sequences for
// arbitration and reset, then random traffic against a transfer-level model.
module tb_mem_port_arbiter;
  localparam int MW = 16;

  logic        clk, rst_n;
  logic        if_req, if_valid, if_err;
  logic [31:0] if_addr, if_rdata;
  logic        dm_req, dm_we, dm_valid, dm_err;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic [3:0]  dm_wstrb;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        stall_if, stall_mem;

  int n_vec = 0;
  int n_err = 0;

  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid), .if_err(if_err),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_wstrb(dm_wstrb),
    .dm_rdata(dm_rdata), .dm_valid(dm_valid), .dm_err(dm_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .stall_if(stall_if), .stall_mem(stall_mem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ready_at: busy cycle (grant cycle = 1) in which mem_ready rises; 0 = never.
  typedef struct {
    bit          is_dm;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    int          ready_at;
    int          exp_cycle;
    bit          exp_err;
  } vec_t;

  vec_t vecs[6];

  task automatic run_vec(input vec_t v);
    logic [31:0] exp_rd;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    mem_rdata = v.rdata;
    if (v.is_dm) begin
      dm_req = 1'b1; dm_we = v.we; dm_addr = v.addr; dm_wdata = v.wdata; dm_wstrb = v.wstrb;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    @(negedge clk);
    chk("req_cycle_mem_req", mem_req, 0);
    chk("req_cycle_stall", v.is_dm ? stall_mem : stall_if, 1);
    for (int b = 1; b <= 40; b++) begin
      @(posedge clk); #1;
      mem_ready = (v.ready_at != 0) && (b >= v.ready_at);
      @(negedge clk);
      chk("busy_mem_req", mem_req, 1);
      chk("busy_mem_addr", mem_addr, v.addr);
      chk("busy_mem_we", mem_we, v.is_dm ? v.we : 1'b0);
      chk("busy_mem_wstrb", mem_wstrb, v.is_dm ? v.wstrb : 4'h0);
      if (v.is_dm && v.we) chk("busy_mem_wdata", mem_wdata, v.wdata);
      chk("busy_other_valid", v.is_dm ? if_valid : dm_valid, 0);
      if (b == v.exp_cycle) begin
        exp_rd = v.exp_err ? 32'h0 : v.rdata;
        chk("done_valid", v.is_dm ? dm_valid : if_valid, 1);
        chk("done_err", v.is_dm ? dm_err : if_err, v.exp_err);
        chk("done_stall", v.is_dm ? stall_mem : stall_if, 0);
        if (!(v.is_dm && v.we)) chk("done_rdata", v.is_dm ? dm_rdata : if_rdata, exp_rd);
        break;
      end else begin
        chk("wait_valid", v.is_dm ? dm_valid : if_valid, 0);
        chk("wait_stall", v.is_dm ? stall_mem : stall_if, 1);
      end
    end
    @(posedge clk); #1;
    if_req = 1'b0; dm_req = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    chk("after_mem_req", mem_req, 0);
    chk("after_valid", {if_valid, dm_valid}, 0);
  endtask

  // transfer-level reference model state
  int          m_own;  // 0 none, 1 fetch, 2 data
  int          m_cnt;  // busy cycle number, grant cycle = 1
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_we;
  bit          tmo, done, e_ifv, e_dmv, p_if_v, p_dm_v;
  int          stuck;

  initial begin
    rst_n = 1'b0;
    if_req = 1'b1; if_addr = 32'h0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = 32'h0; dm_wdata = 32'h0; dm_wstrb = 4'h0;
    mem_ready = 1'b1; mem_rdata = 32'hA5A5_A5A5;
    #12;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_wstrb", mem_wstrb, 0);
    chk("rst_valid_err", {if_valid, if_err, dm_valid, dm_err}, 0);
    chk("rst_rdata", {if_rdata, dm_rdata}, 0);
    chk("rst_stall_if", stall_if, 1);
    chk("rst_stall_mem", stall_mem, 0);
    if_req = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    vecs[0] = '{0, 0, 32'h100,  32'h0,        4'h0, 32'h0000_0013, 1, 1, 0};
    vecs[1] = '{1, 1, 32'h3000, 32'hDEAD_BEEF, 4'h3, 32'h1234_5678, 4, 4, 0};
    vecs[2] = '{1, 0, 32'h2004, 32'h0,        4'hF, 32'hCAFE_F00D, 0, 17, 1};
    vecs[3] = '{1, 0, 32'h2008, 32'h0,        4'hF, 32'h8765_4321, 17, 17, 0};
    vecs[4] = '{0, 0, 32'h204,  32'h0,        4'h0, 32'h0040_0093, 2, 2, 0};
    vecs[5] = '{1, 0, 32'h200C, 32'h0,        4'h1, 32'h0BAD_CAFE, 16, 16, 0};
    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // simultaneous fetch and load: data granted first, fetch two cycles later
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h104;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h2000; dm_wstrb = 4'hF;
    mem_ready = 1'b1; mem_rdata = 32'h5555_AAAA;
    @(negedge clk);
    chk("arb_c0_stall", {stall_if, stall_mem}, 2'b11);
    @(posedge clk); #1;
    @(negedge clk);
    chk("arb_c1_addr", mem_addr, 32'h2000);
    chk("arb_c1_dm_valid", dm_valid, 1);
    chk("arb_c1_if_valid", if_valid, 0);
    chk("arb_c1_stall_if", stall_if, 1);
    chk("arb_c1_rdata", dm_rdata, 32'h5555_AAAA);
    @(posedge clk); #1;
    dm_req = 1'b0;
    @(negedge clk);
    chk("arb_c2_mem_req", mem_req, 0);
    chk("arb_c2_stall_if", stall_if, 1);
    @(posedge clk); #1;
    mem_rdata = 32'h0000_0013;
    @(negedge clk);
    chk("arb_c3_addr", mem_addr, 32'h104);
    chk("arb_c3_we", mem_we, 0);
    chk("arb_c3_if_valid", if_valid, 1);
    chk("arb_c3_rdata", if_rdata, 32'h0000_0013);
    @(posedge clk); #1;
    if_req = 1'b0; mem_ready = 1'b0;
    @(negedge clk);

    // reset during DM_BUSY with a fetch waiting
    @(posedge clk); #1;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h4000; dm_wstrb = 4'hF;
    if_req = 1'b1; if_addr = 32'h108;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstmid_busy_req", mem_req, 1);
    chk("rstmid_busy_addr", mem_addr, 32'h4000);
    @(posedge clk); #2;
    mem_ready = 1'b1; rst_n = 1'b0;
    #1;
    chk("rstmid_mem_req", mem_req, 0);
    chk("rstmid_valid", {if_valid, dm_valid}, 0);
    chk("rstmid_stall", {stall_if, stall_mem}, 2'b11);
    @(posedge clk); #1;
    dm_req = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rstmid_release_req", mem_req, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstmid_if_req", mem_req, 1);
    chk("rstmid_if_addr", mem_addr, 32'h108);
    chk("rstmid_if_we", {mem_we, mem_wstrb}, 0);
    chk("rstmid_if_wait", if_valid, 0);
    @(posedge clk); #1;
    mem_ready = 1'b1; mem_rdata = 32'h1122_3344;
    @(negedge clk);
    chk("rstmid_if_valid", if_valid, 1);
    chk("rstmid_if_rdata", if_rdata, 32'h1122_3344);
    @(posedge clk); #1;
    if_req = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    chk("rstmid_end_req", mem_req, 0);

    // random traffic against the model
    m_own = 0; m_cnt = 0; p_if_v = 0; p_dm_v = 0; stuck = 0;
    m_addr = 0; m_wdata = 0; m_wstrb = 0; m_we = 0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      if (!if_req || p_if_v) begin
        if_req = 1'($urandom_range(0, 1));
        if_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!dm_req || p_dm_v) begin
        dm_req = ($urandom_range(0, 2) == 0);
        dm_we = 1'($urandom_range(0, 1));
        dm_addr = $urandom;
        dm_wdata = $urandom;
        dm_wstrb = 4'($urandom_range(0, 15));
      end
      if (stuck > 0) begin
        mem_ready = 1'b0; stuck--;
      end else if ($urandom_range(0, 99) == 0) begin
        mem_ready = 1'b0; stuck = 20;
      end else begin
        mem_ready = ($urandom_range(0, 9) < 6);
      end
      mem_rdata = $urandom;
      @(negedge clk);
      tmo   = (m_own != 0) && !mem_ready && (m_cnt == MW + 1);
      done  = (m_own != 0) && (mem_ready || tmo);
      e_ifv = (m_own == 1) && done;
      e_dmv = (m_own == 2) && done;
      chk("rnd_mem_req", mem_req, m_own != 0);
      if (m_own != 0) begin
        chk("rnd_mem_addr", mem_addr, m_addr);
        chk("rnd_mem_we", mem_we, m_we);
        chk("rnd_mem_wstrb", mem_wstrb, m_wstrb);
        if (m_own == 2) chk("rnd_mem_wdata", mem_wdata, m_wdata);
      end
      chk("rnd_if_valid", if_valid, e_ifv);
      chk("rnd_if_err", if_err, (m_own == 1) && tmo);
      chk("rnd_if_rdata", if_rdata, ((m_own == 1) && mem_ready) ? mem_rdata : 32'h0);
      chk("rnd_dm_valid", dm_valid, e_dmv);
      chk("rnd_dm_err", dm_err, (m_own == 2) && tmo);
      if (!(e_dmv && m_we))
        chk("rnd_dm_rdata", dm_rdata, ((m_own == 2) && mem_ready) ? mem_rdata : 32'h0);
      chk("rnd_stall_if", stall_if, if_req && !e_ifv);
      chk("rnd_stall_mem", stall_mem, dm_req && !e_dmv);
      p_if_v = e_ifv;
      p_dm_v = e_dmv;
      if (done) begin
        m_own = 0;
      end else if (m_own != 0) begin
        m_cnt++;
      end else if (dm_req) begin
        m_own = 2; m_cnt = 1;
        m_addr = dm_addr; m_we = dm_we; m_wdata = dm_wdata; m_wstrb = dm_wstrb;
      end else if (if_req) begin
        m_own = 1; m_cnt = 1;
        m_addr = if_addr; m_we = 1'b0; m_wstrb = 4'h0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
